// File: rtl/excp_commit_ctrl_if.sv
// Commit-side bundle between WB, the CSR file and fetch.
// slave: commit controller view; master: WB/CSR/fetch view.
interface excp_commit_ctrl_if;
  logic        ws_valid;
  logic        ws_ready;
  logic [31:0] ws_pc;
  logic [4:0]  ws_excp_vec;
  logic        ws_is_ertn;
  logic        ws_csr_we;
  logic [13:0] ws_csr_num;
  logic [31:0] ws_csr_wmask;
  logic [31:0] ws_csr_wdata;
  logic        has_int;
  logic [31:0] era;
  logic [31:0] eentry;
  logic        csr_we;
  logic [13:0] csr_num;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wdata;
  logic        excp_flush;
  logic        ertn_flush;
  logic [5:0]  ecode;
  logic [2:0]  esubcode;
  logic [31:0] epc;
  logic        pipe_flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;

  modport slave (
    input  ws_valid, ws_pc, ws_excp_vec,
    input  ws_is_ertn, ws_csr_we, ws_csr_num,
    input  ws_csr_wmask, ws_csr_wdata,
    input  has_int, era, eentry,
    input  redirect_ready,
    output ws_ready,
    output csr_we, csr_num, csr_wmask, csr_wdata,
    output excp_flush, ertn_flush,
    output ecode, esubcode, epc, pipe_flush,
    output redirect_valid, redirect_pc
  );

  modport master (
    output ws_valid, ws_pc, ws_excp_vec,
    output ws_is_ertn, ws_csr_we, ws_csr_num,
    output ws_csr_wmask, ws_csr_wdata,
    output has_int, era, eentry,
    output redirect_ready,
    input  ws_ready,
    input  csr_we, csr_num, csr_wmask, csr_wdata,
    input  excp_flush, ertn_flush,
    input  ecode, esubcode, epc, pipe_flush,
    input  redirect_valid, redirect_pc
  );
endinterface

// File: rtl/excp_commit_ctrl.sv
// WB commit controller: exception/ERTN arbitration, CSR write, redirect.
// Ports: clk, reset (sync, high), bus (excp_commit_ctrl_if.slave).
module excp_commit_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input logic              clk,
  input logic              reset,
  excp_commit_ctrl_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REDIR = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [5:0] EC_INT  = 6'h00;
  localparam logic [5:0] EC_ADEF = 6'h08;
  localparam logic [5:0] EC_INE  = 6'h0D;
  localparam logic [5:0] EC_SYS  = 6'h0B;
  localparam logic [5:0] EC_BRK  = 6'h0C;
  localparam logic [5:0] EC_ALE  = 6'h09;

  localparam logic [3:0] CNT_INIT = 4'(DRAIN_CYCLES - 1);

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [31:0] rpc;

  logic        adef, ine, sys, brk, ale;
  logic        has_ex;
  logic        commit;
  logic        take_excp;
  logic        take_ertn;
  logic        take_csr;
  logic [5:0]  ecode_sel;

  assign {adef, ine, sys, brk, ale} = bus.ws_excp_vec;

  assign bus.ws_ready = (state == S_IDLE);

  assign has_ex    = bus.has_int | (|bus.ws_excp_vec);
  assign commit    = bus.ws_valid & bus.ws_ready;
  assign take_excp = commit & has_ex;
  assign take_ertn = commit & bus.ws_is_ertn & ~has_ex;
  assign take_csr  = commit & bus.ws_csr_we
                   & ~take_excp & ~take_ertn;

  // Terms are made mutually exclusive so the
  // first-match priority survives a unique case.
  always_comb begin
    ecode_sel = EC_INT;
    unique case (1'b1)
      bus.has_int:
        ecode_sel = EC_INT;
      !bus.has_int && adef:
        ecode_sel = EC_ADEF;
      !bus.has_int && !adef && ine:
        ecode_sel = EC_INE;
      !bus.has_int && !adef && !ine && sys:
        ecode_sel = EC_SYS;
      !bus.has_int && !adef && !ine && !sys && brk:
        ecode_sel = EC_BRK;
      !bus.has_int && !adef && !ine && !sys && !brk && ale:
        ecode_sel = EC_ALE;
      default:
        ecode_sel = EC_INT;
    endcase
  end

  assign bus.excp_flush = take_excp;
  assign bus.ertn_flush = take_ertn;
  assign bus.pipe_flush = take_excp | take_ertn;
  assign bus.ecode      = take_excp ? ecode_sel : 6'd0;
  assign bus.esubcode   = 3'd0;
  assign bus.epc        = take_excp ? bus.ws_pc : 32'd0;

  assign bus.csr_we    = take_csr;
  assign bus.csr_num   = take_csr ? bus.ws_csr_num   : 14'd0;
  assign bus.csr_wmask = take_csr ? bus.ws_csr_wmask : 32'd0;
  assign bus.csr_wdata = take_csr ? bus.ws_csr_wdata : 32'd0;

  assign bus.redirect_valid = (state == S_REDIR);
  assign bus.redirect_pc    = rpc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
      rpc   <= 32'd0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (take_excp) begin
            state <= S_REDIR;
            rpc   <= bus.eentry;
          end else if (take_ertn) begin
            state <= S_REDIR;
            rpc   <= bus.era;
          end
        end
        S_REDIR: begin
          if (bus.redirect_ready) begin
            state <= S_DRAIN;
            cnt   <= CNT_INIT;
          end
        end
        S_DRAIN: begin
          if (cnt == 4'd0) begin
            state <= S_IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

endmodule
